// File: rtl/ota_bitstream_decimator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ota_pkg                                                    |
// | Purpose  : Shared types, constants and helpers for the OTA decimator  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package ota_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] WIN_32  = 2'd0;
  localparam logic [1:0] WIN_64  = 2'd1;
  localparam logic [1:0] WIN_128 = 2'd2;
  localparam logic [1:0] WIN_256 = 2'd3;

  localparam int OUT_MAX = 255;
  localparam int CNT_W   = 9;

  function automatic logic [CNT_W-1:0] win_len(input logic [1:0] win);
    return CNT_W'(32) << win;
  endfunction

  // Scale every window length up to a 256-sample equivalent, then clip.
  function automatic logic [7:0] normalise(input logic [CNT_W-1:0] cnt,
                                           input logic [1:0]       win);
    logic [CNT_W+2:0] shifted;
    shifted = {3'b000, cnt} << (2'd3 - win);
    return (shifted > (CNT_W+3)'(OUT_MAX)) ? 8'(OUT_MAX) : shifted[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ota_bitstream_decimator_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ota_bitstream_decimator_if                                 |
// | Purpose  : Result valid/ready readout bundle with producer/consumer   |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
interface ota_bitstream_decimator_if #(
  parameter int OUT_W = 8
);
  logic [OUT_W-1:0] result;
  logic             result_valid;
  logic             result_ready;
  logic             overrun;

  modport master (output result, output result_valid, output overrun, input result_ready);
  modport slave  (input result, input result_valid, input overrun, output result_ready);
endinterface
`default_nettype wire

// File: rtl/ota_bitstream_decimator_bit_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bit_sync                                                   |
// | Purpose  : N-stage flop synchroniser, async active-low reset          |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module bit_sync #(
  parameter int STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic d_i,
  output logic      q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ota_bitstream_decimator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ota_bitstream_decimator                                    |
// | Purpose  : Windowed ones-count of the OTA bitstream -> 8-bit level    |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module ota_bitstream_decimator
  import ota_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int OUT_W       = 8
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       ena,
  input  wire logic       bit_in,
  input  wire logic       start,
  input  wire logic       cont,
  input  wire logic [1:0] win_sel,
  output logic            busy,
  ota_bitstream_decimator_if.master rd
);

  logic s_bit;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bit_in),
    .q_o   (s_bit)
  );

  state_e           state_q, state_d;
  logic [1:0]       win_q, win_d;
  logic [CNT_W-1:0] samp_q, samp_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [1:0]       dwin_q, dwin_d;

  logic [CNT_W-1:0] samp_inc;
  logic [CNT_W-1:0] ones_inc;
  logic             last_sample;

  assign samp_inc    = samp_q + CNT_W'(1);
  assign ones_inc    = ones_q + CNT_W'(s_bit);
  assign last_sample = (samp_inc == win_len(win_q));

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    samp_d  = samp_q;
    ones_d  = ones_q;
    done_d  = 1'b0;
    dcnt_d  = dcnt_q;
    dwin_d  = dwin_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          win_d   = win_sel;
          samp_d  = '0;
          ones_d  = '0;
        end
      end
      RUN: begin
        samp_d = samp_inc;
        ones_d = ones_inc;
        if (last_sample) begin
          // Final count is parked so counters can restart with no gap.
          done_d = 1'b1;
          dcnt_d = ones_inc;
          dwin_d = win_q;
          samp_d = '0;
          ones_d = '0;
          if (cont) begin
            win_d = win_sel;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      samp_q  <= '0;
      ones_q  <= '0;
      done_q  <= 1'b0;
      dcnt_q  <= '0;
      dwin_q  <= '0;
    end else if (ena) begin
      state_q <= state_d;
      win_q   <= win_d;
      samp_q  <= samp_d;
      ones_q  <= ones_d;
      done_q  <= done_d;
      dcnt_q  <= dcnt_d;
      dwin_q  <= dwin_d;
    end
  end

  logic [OUT_W-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             xfer, load, accept;

  assign xfer   = valid_q && rd.result_ready;
  assign load   = ena && done_q;
  assign accept = load && (!valid_q || xfer);

  always_comb begin
    result_d  = result_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (accept) begin
      result_d = normalise(dcnt_q, dwin_q);
      valid_d  = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    if (ena) begin
      if (load && !accept) begin
        overrun_d = 1'b1;
      end else if (xfer) begin
        overrun_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy            = (state_q == RUN);
  assign rd.result       = result_q;
  assign rd.result_valid = valid_q;
  assign rd.overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ota_bitstream_decimator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ota_bitstream_decimator                                 |
// | Purpose  : Table + scoreboard bench for the OTA bitstream decimator   |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ota_bitstream_decimator;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       bit_in;
  logic       start;
  logic       cont;
  logic [1:0] win_sel;
  logic       busy;
  logic       ready;

  int checks = 0;
  int errors = 0;
  int pat    = 0;
  int cyc    = 0;

  logic [7:0] sb[$];

  ota_bitstream_decimator_if #(.OUT_W(8)) rd_if ();
  assign rd_if.result_ready = ready;

  ota_bitstream_decimator #(.SYNC_STAGES(2), .OUT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .bit_in  (bit_in),
    .start   (start),
    .cont    (cont),
    .win_sel (win_sel),
    .busy    (busy),
    .rd      (rd_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Periodic bitstream patterns: 0, 1, 1/2, 1/4, 3/4 density.
  initial begin
    bit_in = 1'b0;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      case (pat)
        1:       bit_in = 1'b1;
        2:       bit_in = cyc[0];
        3:       bit_in = (cyc[1:0] == 2'd0);
        4:       bit_in = (cyc[1:0] != 2'd0);
        default: bit_in = 1'b0;
      endcase
    end
  end

  initial begin
    logic [7:0] exp_v;
    forever begin
      @(negedge clk);
      if (rst_n && rd_if.result_valid && ready) begin
        checks = checks + 1;
        if (sb.size() == 0) begin
          errors = errors + 1;
          $display("FAIL xfer_unexpected: got result=%0d, required no transfer", rd_if.result);
        end else begin
          exp_v = sb.pop_front();
          if (rd_if.result !== exp_v) begin
            errors = errors + 1;
            $display("FAIL xfer_result: got %0d, required %0d", rd_if.result, exp_v);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks = checks + 1;
    if (act !== exp_v) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp_v);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (sb.size() == 0 && !busy && !rd_if.result_valid) ok = 1'b1;
      else tick();
    end
    checks = checks + 1;
    if (!ok) begin
      errors = errors + 1;
      $display("FAIL %s_drain: pending=%0d busy=%0d valid=%0d, required 0 0 0",
               nm, sb.size(), busy, rd_if.result_valid);
      sb.delete();
    end
  endtask

  task automatic wait_valid(input int bound, output int k);
    k = 0;
    for (int i = 1; i <= bound && k == 0; i++) begin
      tick();
      if (rd_if.result_valid) k = i;
    end
  endtask

  typedef struct {
    logic [1:0] win;
    int         p;
    logic [7:0] exp_v;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int k;
    int busy_fall;
    int first_valid;
    bit dropped;

    vecs[0]  = '{2'd0, 1, 8'd255};
    vecs[1]  = '{2'd0, 0, 8'd0};
    vecs[2]  = '{2'd0, 2, 8'd128};
    vecs[3]  = '{2'd1, 2, 8'd128};
    vecs[4]  = '{2'd3, 2, 8'd128};
    vecs[5]  = '{2'd2, 3, 8'd64};
    vecs[6]  = '{2'd3, 1, 8'd255};
    vecs[7]  = '{2'd1, 1, 8'd255};
    vecs[8]  = '{2'd1, 3, 8'd64};
    vecs[9]  = '{2'd3, 0, 8'd0};
    vecs[10] = '{2'd0, 4, 8'd192};
    vecs[11] = '{2'd3, 4, 8'd192};
    vecs[12] = '{2'd2, 4, 8'd192};
    vecs[13] = '{2'd0, 3, 8'd64};

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; cont = 1'b0;
    win_sel = 2'd0; ready = 1'b0;
    tick(); tick();
    chk("rst_result",  32'(rd_if.result), 0);
    chk("rst_valid",   32'(rd_if.result_valid), 0);
    chk("rst_overrun", 32'(rd_if.overrun), 0);
    chk("rst_busy",    32'(busy), 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      pat = vecs[i].p; win_sel = vecs[i].win; ready = 1'b1; cont = 1'b0;
      repeat (5) tick();
      sb.push_back(vecs[i].exp_v);
      pulse_start();
      drain($sformatf("vec%0d", i));
    end

    // Latency: valid 33 cycles after start accept, busy for 32.
    pat = 1; win_sel = 2'd0; ready = 1'b0;
    repeat (5) tick();
    pulse_start();
    chk("a_busy_after_start", 32'(busy), 1);
    busy_fall = 0; first_valid = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (!busy && busy_fall == 0) busy_fall = i;
      if (rd_if.result_valid && first_valid == 0) first_valid = i;
    end
    chk("a_busy_len", busy_fall, 32);
    chk("a_valid_latency", first_valid, 33);
    chk("a_result", 32'(rd_if.result), 255);
    sb.push_back(8'd255);
    ready = 1'b1;
    drain("a");

    // Overrun: continuous windows with the consumer stalled.
    pat = 0; win_sel = 2'd0; cont = 1'b1; ready = 1'b0;
    repeat (5) tick();
    pulse_start();
    wait_valid(40, k);
    chk("b_first_valid_k", k, 33);
    chk("b_first_result", 32'(rd_if.result), 0);
    chk("b_no_overrun_yet", 32'(rd_if.overrun), 0);
    repeat (33) tick();
    chk("b_overrun_set", 32'(rd_if.overrun), 1);
    chk("b_result_kept", 32'(rd_if.result), 0);
    cont = 1'b0; ready = 1'b1;
    sb.push_back(8'd0);
    sb.push_back(8'd0);
    tick();
    chk("b_overrun_cleared", 32'(rd_if.overrun), 0);
    chk("b_valid_after_xfer", 32'(rd_if.result_valid), 0);
    drain("b");

    // Completion coincident with transfer: valid stays high, new value loads.
    pat = 1; win_sel = 2'd0; cont = 1'b1; ready = 1'b0;
    repeat (5) tick();
    sb.push_back(8'd255);
    sb.push_back(8'd0);
    sb.push_back(8'd0);
    pulse_start();
    dropped = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 30) pat = 0;
      if (i == 33) chk("c_first_result", 32'(rd_if.result), 255);
      if (i >= 33 && !rd_if.result_valid) dropped = 1'b1;
    end
    ready = 1'b1;
    tick();
    chk("c_valid_held", 32'(rd_if.result_valid), 1);
    chk("c_overrun_clear", 32'(rd_if.overrun), 0);
    chk("c_new_result", 32'(rd_if.result), 0);
    chk("c_valid_never_dropped", 32'(dropped), 0);
    cont = 1'b0;
    drain("c");

    // Clock-enable freeze for 10 cycles mid-window.
    pat = 2; win_sel = 2'd0; cont = 1'b0; ready = 1'b0;
    repeat (5) tick();
    pulse_start();
    busy_fall = 0; first_valid = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (i == 10) ena = 1'b0;
      if (i == 20) ena = 1'b1;
      if (i == 15) chk("d_busy_frozen", 32'(busy), 1);
      if (!busy && busy_fall == 0) busy_fall = i;
      if (rd_if.result_valid && first_valid == 0) first_valid = i;
    end
    chk("d_busy_len", busy_fall, 42);
    chk("d_valid_latency", first_valid, 43);
    sb.push_back(8'd128);
    ready = 1'b1;
    drain("d");

    // Asynchronous reset mid-window with a held result and overrun.
    pat = 1; win_sel = 2'd0; cont = 1'b0; ready = 1'b0;
    repeat (5) tick();
    pulse_start();
    wait_valid(40, k);
    chk("e_first_valid_k", k, 33);
    pulse_start();
    repeat (34) tick();
    chk("e_overrun_set", 32'(rd_if.overrun), 1);
    pulse_start();
    repeat (15) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("e_rst_result",  32'(rd_if.result), 0);
    chk("e_rst_valid",   32'(rd_if.result_valid), 0);
    chk("e_rst_overrun", 32'(rd_if.overrun), 0);
    chk("e_rst_busy",    32'(busy), 0);
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk("e_idle_busy",  32'(busy), 0);
    chk("e_idle_valid", 32'(rd_if.result_valid), 0);
    sb.push_back(8'd255);
    ready = 1'b1;
    pulse_start();
    drain("e");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
